// File: rtl/tff_bank_pkg.sv
// Shared types and parameter limits for the tff_bank flip-flop bank.
package tff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_T  = 2'b00,
        MODE_D  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } tff_mode_t;

    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 32;
    localparam int CNT_W_MIN    = 2;
    localparam int CNT_W_MAX    = 16;

endpackage

// File: rtl/tff_bank_if.sv
// Control/data bundle between a tff_bank and whatever drives it.
interface tff_bank_if #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 8
);
    import tff_bank_pkg::*;

    logic                      en;
    tff_mode_t                 mode;
    logic [CHANNELS-1:0]       a;
    logic [CHANNELS-1:0]       b;
    logic                      ld;
    logic [CHANNELS-1:0]       ld_val;
    logic                      cnt_clr;
    logic [CHANNELS-1:0]       q;
    logic [CHANNELS*CNT_W-1:0] cnt;
    logic                      sr_ill;

    modport master (
        output en, mode, a, b, ld, ld_val, cnt_clr,
        input  q, cnt, sr_ill
    );

    modport slave (
        input  en, mode, a, b, ld, ld_val, cnt_clr,
        output q, cnt, sr_ill
    );

endinterface

// File: rtl/tff_cell.sv
// One channel: q flop with T/D/JK/SR next-state, saturating transition counter
// and a combinational strobe for the illegal S=R=1 condition.
module tff_cell
    import tff_bank_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  tff_mode_t        mode,
    input  logic             a,
    input  logic             b,
    input  logic             ld,
    input  logic             ld_val,
    input  logic             cnt_clr,
    output logic             q,
    output logic [CNT_W-1:0] cnt,
    output logic             ill
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic q_next;

    // Load beats the mode function; the illegal strobe only fires on a real SR update.
    always_comb begin
        q_next = q;
        ill    = 1'b0;
        if (ld) begin
            q_next = ld_val;
        end else if (en) begin
            case (mode)
                MODE_T:  q_next = a ? ~q : q;
                MODE_D:  q_next = a;
                MODE_JK: begin
                    case ({a, b})
                        2'b10:   q_next = 1'b1;
                        2'b01:   q_next = 1'b0;
                        2'b11:   q_next = ~q;
                        default: q_next = q;
                    endcase
                end
                MODE_SR: begin
                    case ({a, b})
                        2'b10:   q_next = 1'b1;
                        2'b01:   q_next = 1'b0;
                        2'b11:   ill    = 1'b1;
                        default: q_next = q;
                    endcase
                end
                default: q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= q_next;
        end
    end

    // Clear takes precedence over a same-cycle transition; the counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if ((q_next != q) && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tff_bank.sv
// Bank of CHANNELS tff_cell channels with a sticky illegal-SR flag.
// Define TFF_BANK_INPUT_SYNC_EN to pass a/b through 2-flop synchronisers.
module tff_bank
    import tff_bank_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 8
) (
    input logic       clk,
    input logic       rst,
    tff_bank_if.slave bus
);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
        CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_param_check
        $error("tff_bank: CHANNELS or CNT_W out of range");
    end

    logic [CHANNELS-1:0] a_use;
    logic [CHANNELS-1:0] b_use;
    logic [CHANNELS-1:0] ill_strobe;

`ifdef TFF_BANK_INPUT_SYNC_EN
    logic [CHANNELS-1:0] a_s1, a_s2;
    logic [CHANNELS-1:0] b_s1, b_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_s1 <= '0;
            a_s2 <= '0;
            b_s1 <= '0;
            b_s2 <= '0;
        end else begin
            a_s1 <= bus.a;
            a_s2 <= a_s1;
            b_s1 <= bus.b;
            b_s2 <= b_s1;
        end
    end

    assign a_use = a_s2;
    assign b_use = b_s2;
`else
    assign a_use = bus.a;
    assign b_use = bus.b;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
        tff_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.en),
            .mode    (bus.mode),
            .a       (a_use[i]),
            .b       (b_use[i]),
            .ld      (bus.ld),
            .ld_val  (bus.ld_val[i]),
            .cnt_clr (bus.cnt_clr),
            .q       (bus.q[i]),
            .cnt     (bus.cnt[i*CNT_W +: CNT_W]),
            .ill     (ill_strobe[i])
        );
    end

    // Sticky flag; a same-cycle counter clear wins over a new illegal strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sr_ill <= 1'b0;
        end else if (bus.cnt_clr) begin
            bus.sr_ill <= 1'b0;
        end else if (|ill_strobe) begin
            bus.sr_ill <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tff_bank.sv
// Bench for tff_bank: two instances (CNT_W=8 and CNT_W=2) share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_tff_bank;
    import tff_bank_pkg::*;

`ifdef TFF_BANK_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic      clk;
    logic      rst;
    logic      en_in;
    tff_mode_t mode_in;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic      ld_in;
    logic [7:0] ldv_in;
    logic      clr_in;

    int checks   = 0;
    int failures = 0;

    tff_bank_if #(.CHANNELS(8), .CNT_W(8)) bus8 ();
    tff_bank_if #(.CHANNELS(8), .CNT_W(2)) bus2 ();

    assign bus8.en = en_in;   assign bus2.en = en_in;
    assign bus8.mode = mode_in; assign bus2.mode = mode_in;
    assign bus8.a = a_in;     assign bus2.a = a_in;
    assign bus8.b = b_in;     assign bus2.b = b_in;
    assign bus8.ld = ld_in;   assign bus2.ld = ld_in;
    assign bus8.ld_val = ldv_in; assign bus2.ld_val = ldv_in;
    assign bus8.cnt_clr = clr_in; assign bus2.cnt_clr = clr_in;

    tff_bank #(.CHANNELS(8), .CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    tff_bank #(.CHANNELS(8), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Behavioural model: characteristic equations per channel, counters as saturating ints.
    logic [7:0] m_q = '0;
    bit         m_ill = 1'b0;
    int         m_cnt8 [8];
    int         m_cnt2 [8];
    logic [7:0] m_a1 = '0, m_a2 = '0, m_b1 = '0, m_b2 = '0;

    always @(posedge clk or posedge rst) begin : model
        logic [7:0] ea, eb, nq;
        bit hit, j, k, cur;
        if (rst) begin
            m_q = '0;
            m_ill = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_cnt8[i] = 0;
                m_cnt2[i] = 0;
            end
            m_a1 = '0; m_a2 = '0; m_b1 = '0; m_b2 = '0;
        end else begin
`ifdef TFF_BANK_INPUT_SYNC_EN
            ea = m_a2; eb = m_b2;
            m_a2 = m_a1; m_b2 = m_b1;
            m_a1 = a_in; m_b1 = b_in;
`else
            ea = a_in; eb = b_in;
`endif
            nq = m_q;
            hit = 1'b0;
            if (ld_in) begin
                nq = ldv_in;
            end else if (en_in) begin
                for (int i = 0; i < 8; i++) begin
                    j = ea[i]; k = eb[i]; cur = m_q[i];
                    if (mode_in == MODE_T)       nq[i] = cur ^ j;
                    else if (mode_in == MODE_D)  nq[i] = j;
                    else if (mode_in == MODE_JK) nq[i] = (j & ~cur) | (~k & cur);
                    else if (j && k)             hit = 1'b1;
                    else                         nq[i] = j | (cur & ~k);
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (clr_in) begin
                    m_cnt8[i] = 0;
                    m_cnt2[i] = 0;
                end else if (nq[i] != m_q[i]) begin
                    m_cnt8[i] = (m_cnt8[i] < 255) ? m_cnt8[i] + 1 : 255;
                    m_cnt2[i] = (m_cnt2[i] < 3) ? m_cnt2[i] + 1 : 3;
                end
            end
            if (clr_in)   m_ill = 1'b0;
            else if (hit) m_ill = 1'b1;
            m_q = nq;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [63:0] exp8;
        logic [15:0] exp2;
        for (int i = 0; i < 8; i++) begin
            exp8[i*8 +: 8] = 8'(m_cnt8[i]);
            exp2[i*2 +: 2] = 2'(m_cnt2[i]);
        end
        checkOutput("model_q8",   64'(bus8.q),      64'(m_q));
        checkOutput("model_q2",   64'(bus2.q),      64'(m_q));
        checkOutput("model_cnt8", bus8.cnt,         exp8);
        checkOutput("model_cnt2", 64'(bus2.cnt),    64'(exp2));
        checkOutput("model_ill8", 64'(bus8.sr_ill), 64'(m_ill));
        checkOutput("model_ill2", 64'(bus2.sr_ill), 64'(m_ill));
    end

    // Pre-fills the input synchronisers (en=0) so a/b land on the update edge in either build.
    task automatic applyStimulus(input bit e, input tff_mode_t m, input logic [7:0] aa,
                                 input logic [7:0] bb, input bit l, input logic [7:0] lv, input bit c);
        if (LAT > 0) begin
            en_in = 1'b0; ld_in = 1'b0; clr_in = 1'b0;
            a_in = aa; b_in = bb;
            repeat (LAT) @(negedge clk);
        end
        en_in = e; mode_in = m; a_in = aa; b_in = bb;
        ld_in = l; ldv_in = lv; clr_in = c;
        @(negedge clk);
    endtask

    initial begin
        int exp_c2 [5];
        exp_c2 = '{1, 2, 3, 3, 3};
        rst = 1'b1;
        en_in = 1'b0; mode_in = MODE_T; a_in = '0; b_in = '0;
        ld_in = 1'b0; ldv_in = '0; clr_in = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_q",   64'(bus8.q),      64'h0);
        checkOutput("reset_cnt", bus8.cnt,         64'h0);
        checkOutput("reset_ill", 64'(bus8.sr_ill), 64'h0);
        rst = 1'b0;

        // T mode toggling channel 0; the CNT_W=2 copy saturates at 3
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b1, MODE_T, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
            checkOutput("t_q0",    64'(bus8.q[0]),   64'((s % 2 == 0) ? 1 : 0));
            checkOutput("t_cnt2",  64'(bus2.cnt[1:0]), 64'(exp_c2[s]));
        end
        checkOutput("t_cnt8_0", 64'(bus8.cnt[7:0]), 64'd5);
        checkOutput("t_q_rest", 64'(bus8.q[7:1]),   64'h0);

        // D mode: second identical sample changes nothing
        applyStimulus(1'b1, MODE_D, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("d_q1",    64'(bus8.q), 64'hA5);
        checkOutput("d_cnt8a", bus8.cnt,    64'h0100010000010005);
        applyStimulus(1'b1, MODE_D, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("d_q2",    64'(bus8.q),   64'hA5);
        checkOutput("d_cnt8b", bus8.cnt,      64'h0100010000010005);
        checkOutput("d_cnt2",  64'(bus2.cnt), 64'h4413);

        // JK sequence from q=0 after a load and counter clear
        applyStimulus(1'b0, MODE_JK, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
        checkOutput("ld_q0", 64'(bus8.q), 64'h0);
        applyStimulus(1'b0, MODE_JK, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        checkOutput("clr_cnt", bus8.cnt, 64'h0);
        applyStimulus(1'b1, MODE_JK, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("jk_10", 64'(bus8.q), 64'h01);
        applyStimulus(1'b1, MODE_JK, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
        checkOutput("jk_11", 64'(bus8.q), 64'h00);
        applyStimulus(1'b1, MODE_JK, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0);
        checkOutput("jk_01", 64'(bus8.q), 64'h00);
        applyStimulus(1'b1, MODE_JK, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("jk_00",   64'(bus8.q), 64'h00);
        checkOutput("jk_cnt8", bus8.cnt,    64'h2);

        // SR illegal, clear, and a load during SR with S=R=1
        applyStimulus(1'b1, MODE_SR, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
        checkOutput("sr_q",   64'(bus8.q),      64'h00);
        checkOutput("sr_ill", 64'(bus8.sr_ill), 64'h1);
        applyStimulus(1'b0, MODE_SR, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        checkOutput("sr_clr_ill", 64'(bus8.sr_ill), 64'h0);
        checkOutput("sr_clr_cnt", bus8.cnt,         64'h0);
        applyStimulus(1'b1, MODE_SR, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0);
        checkOutput("ldsr_q",   64'(bus8.q),      64'hFF);
        checkOutput("ldsr_ill", 64'(bus8.sr_ill), 64'h0);
        checkOutput("ldsr_cnt", bus8.cnt,         64'h0101010101010101);

        // Asynchronous reset between edges
        applyStimulus(1'b1, MODE_SR, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
        checkOutput("pre_rst_ill", 64'(bus8.sr_ill), 64'h1);
        en_in = 1'b0; a_in = '0; b_in = '0;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_q",    64'(bus8.q),      64'h0);
        checkOutput("arst_cnt8", bus8.cnt,         64'h0);
        checkOutput("arst_cnt2", 64'(bus2.cnt),    64'h0);
        checkOutput("arst_ill",  64'(bus8.sr_ill), 64'h0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Pulse a[0] for one edge; toggle appears LAT edges later
        en_in = 1'b1; mode_in = MODE_T; a_in = 8'h01; b_in = 8'h00;
        @(negedge clk);
        a_in = 8'h00;
        checkOutput("lat_e0", 64'(bus8.q[0]), 64'((0 >= LAT) ? 1 : 0));
        @(negedge clk);
        checkOutput("lat_e1", 64'(bus8.q[0]), 64'((1 >= LAT) ? 1 : 0));
        @(negedge clk);
        checkOutput("lat_e2", 64'(bus8.q[0]), 64'((2 >= LAT) ? 1 : 0));

        // Long toggle run drives every 8-bit counter to saturation
        en_in = 1'b1; mode_in = MODE_T; a_in = 8'hFF;
        repeat (262) @(negedge clk);
        checkOutput("sat_cnt8", bus8.cnt,      64'hFFFFFFFFFFFFFFFF);
        checkOutput("sat_cnt2", 64'(bus2.cnt), 64'hFFFF);

        // Randomised traffic with occasional mid-cycle resets
        for (int n = 0; n < 1500; n++) begin
            en_in   = ($urandom_range(0, 3) != 0);
            mode_in = tff_mode_t'(2'($urandom_range(0, 3)));
            a_in    = 8'($urandom);
            b_in    = 8'($urandom);
            ld_in   = ($urandom_range(0, 15) == 0);
            ldv_in  = 8'($urandom);
            clr_in  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
